// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, stage control record and Tnew helper for pipeline boundary registers
package pipe_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W = 32;
    localparam int TNEW_MAX_W = 8;
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] a3;
        logic [TNEW_MAX_W-1:0] tnew;
    } ctrl_t;
    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] tnew);
        return (tnew == '0) ? '0 : tnew - 1'b1;
    endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: one forwarding/hazard query port against a stage's registered control record
module fwd_match
    import pipe_pkg::*;
(
    input  ctrl_t                 ctrl,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic                  rdy,
    output logic                  stall
);
    assign hit   = ctrl.valid & ctrl.we & (ctrl.a3 == addr) & (addr != '0);
    assign rdy   = hit & (ctrl.tnew == '0);
    assign stall = hit & (ctrl.tnew != '0);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with flush, stall hold, Tnew countdown and forwarding queries
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int TNEW_W    = 2,
    parameter int NUM_SRC   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          valid_i,
    input  logic [REG_ADDR_W-1:0]         a3_i,
    input  logic                          we_i,
    input  logic [TNEW_W-1:0]             tnew_i,
    input  logic [WORD_W-1:0]             wd_i,
    input  logic [PAYLOAD_W-1:0]          payload_i,
    output logic                          valid_o,
    output logic [REG_ADDR_W-1:0]         a3_o,
    output logic                          we_o,
    output logic [TNEW_W-1:0]             tnew_o,
    output logic [WORD_W-1:0]             wd_o,
    output logic [PAYLOAD_W-1:0]          payload_o,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
    output logic [NUM_SRC-1:0]            src_hit_o,
    output logic [NUM_SRC-1:0]            src_rdy_o,
    output logic [NUM_SRC-1:0]            src_stall_o,
    output logic [WORD_W-1:0]             fwd_data_o
);
    logic  we_c;
    ctrl_t ctrl;
    assign we_c = we_i & valid_i & (a3_i != '0);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_o   <= 1'b0;
            we_o      <= 1'b0;
            a3_o      <= '0;
            tnew_o    <= '0;
            wd_o      <= '0;
            payload_o <= '0;
        end else if (en) begin
            valid_o   <= valid_i;
            we_o      <= we_c;
            a3_o      <= we_c ? a3_i : '0;
            tnew_o    <= TNEW_W'(tnew_dec(TNEW_MAX_W'(tnew_i)));
            wd_o      <= wd_i;
            payload_o <= payload_i;
        end
    end
    assign ctrl       = '{valid: valid_o, we: we_o, a3: a3_o, tnew: TNEW_MAX_W'(tnew_o)};
    assign fwd_data_o = wd_o;
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match u_match (
            .ctrl  (ctrl),
            .addr  (src_addr_i[k*REG_ADDR_W +: REG_ADDR_W]),
            .hit   (src_hit_o[k]),
            .rdy   (src_rdy_o[k]),
            .stall (src_stall_o[k])
        );
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table plus scoreboard queue for pipe_stage_reg
module tb_pipe_stage_reg;
    logic         clk = 1'b0;
    logic         rst, en, flush, valid_i, we_i;
    logic [4:0]   a3_i;
    logic [1:0]   tnew_i;
    logic [31:0]  wd_i;
    logic [127:0] payload_i;
    logic [9:0]   src_addr_i;
    logic         valid_o, we_o;
    logic [4:0]   a3_o;
    logic [1:0]   tnew_o;
    logic [31:0]  wd_o, fwd_data_o;
    logic [127:0] payload_o;
    logic [1:0]   src_hit_o, src_rdy_o, src_stall_o;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic rst, flush, en, valid, we;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [31:0] wd;
        logic [127:0] pl;
        logic [9:0] src;
    } stim_t;
    typedef struct {
        logic valid, we;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [31:0] wd;
        logic [127:0] pl;
        logic [1:0] hit, rdy, stall;
    } exp_t;
    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;
    vec_t vt[$];
    exp_t sb[$];
    always #5 clk = ~clk;
    pipe_stage_reg #(.PAYLOAD_W(128), .TNEW_W(2), .NUM_SRC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_i(valid_i), .a3_i(a3_i),
        .we_i(we_i), .tnew_i(tnew_i), .wd_i(wd_i), .payload_i(payload_i),
        .valid_o(valid_o), .a3_o(a3_o), .we_o(we_o), .tnew_o(tnew_o), .wd_o(wd_o),
        .payload_o(payload_o), .src_addr_i(src_addr_i), .src_hit_o(src_hit_o),
        .src_rdy_o(src_rdy_o), .src_stall_o(src_stall_o), .fwd_data_o(fwd_data_o)
    );
    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic drive(input stim_t s);
        rst = s.rst; flush = s.flush; en = s.en; valid_i = s.valid; we_i = s.we;
        a3_i = s.a3; tnew_i = s.tnew; wd_i = s.wd; payload_i = s.pl; src_addr_i = s.src;
    endtask
    task automatic check_out(input string t);
        exp_t e;
        if (sb.size() == 0) begin
            chk({t, " sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({t, " valid"}, valid_o, e.valid);
        chk({t, " we"}, we_o, e.we);
        chk({t, " a3"}, a3_o, e.a3);
        chk({t, " tnew"}, tnew_o, e.tnew);
        chk({t, " wd"}, wd_o, e.wd);
        chk({t, " fwd"}, fwd_data_o, e.wd);
        chk({t, " payload"}, payload_o, e.pl);
        chk({t, " hit"}, src_hit_o, e.hit);
        chk({t, " rdy"}, src_rdy_o, e.rdy);
        chk({t, " stall"}, src_stall_o, e.stall);
    endtask
    task automatic apply(input vec_t v, input string t);
        drive(v.s);
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        check_out(t);
    endtask
    initial begin
        // stim: rst flush en valid we a3 tnew wd payload src{p1,p0}
        // exp:  valid we a3 tnew wd payload hit rdy stall
        vt.push_back('{'{1,0,1,1,1,5'd9,2'd3,32'hffff,128'habc,{5'd9,5'd9}}, '{0,0,5'd0,2'd0,32'h0,128'h0,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd5,2'd2,32'h1234,128'h11,{5'd0,5'd5}}, '{1,1,5'd5,2'd1,32'h1234,128'h11,2'b01,2'b00,2'b01}});
        vt.push_back('{'{0,0,1,1,1,5'd5,2'd0,32'h1234,128'h11,{5'd0,5'd5}}, '{1,1,5'd5,2'd0,32'h1234,128'h11,2'b01,2'b01,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd0,2'd0,32'h55,128'h22,{5'd0,5'd0}}, '{1,0,5'd0,2'd0,32'h55,128'h22,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,0,1,5'd6,2'd1,32'h66,128'h33,{5'd6,5'd6}}, '{0,0,5'd0,2'd0,32'h66,128'h33,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd4,2'd2,32'h77,128'h44,{5'd4,5'd0}}, '{1,1,5'd4,2'd1,32'h77,128'h44,2'b10,2'b00,2'b10}});
        for (int i = 0; i < 3; i++)
            vt.push_back('{'{0,0,0,1,1,5'd9,2'd3,32'h99,128'h55,{5'd4,5'd0}}, '{1,1,5'd4,2'd1,32'h77,128'h44,2'b10,2'b00,2'b10}});
        vt.push_back('{'{0,1,0,1,1,5'd9,2'd3,32'h99,128'h55,{5'd4,5'd4}}, '{0,0,5'd0,2'd0,32'h0,128'h0,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd7,2'd3,32'habcd,128'h66,{5'd7,5'd7}}, '{1,1,5'd7,2'd2,32'habcd,128'h66,2'b11,2'b00,2'b11}});
        vt.push_back('{'{0,0,1,1,1,5'd7,2'd0,32'hbeef,128'h77,{5'd7,5'd7}}, '{1,1,5'd7,2'd0,32'hbeef,128'h77,2'b11,2'b11,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd7,2'd0,32'hbeef,128'h77,{5'd8,5'd7}}, '{1,1,5'd7,2'd0,32'hbeef,128'h77,2'b01,2'b01,2'b00}});
        vt.push_back('{'{0,1,1,1,1,5'd8,2'd1,32'h88,128'h88,{5'd8,5'd8}}, '{0,0,5'd0,2'd0,32'h0,128'h0,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd3,2'd1,32'h33,128'h99,{5'd3,5'd0}}, '{1,1,5'd3,2'd0,32'h33,128'h99,2'b10,2'b10,2'b00}});
        vt.push_back('{'{1,0,0,1,1,5'd3,2'd1,32'h33,128'h99,{5'd3,5'd0}}, '{0,0,5'd0,2'd0,32'h0,128'h0,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,1,5'd2,2'd2,32'h22,128'h1,{5'd2,5'd2}}, '{1,1,5'd2,2'd1,32'h22,128'h1,2'b11,2'b00,2'b11}});
        vt.push_back('{'{1,1,1,1,1,5'd2,2'd2,32'h22,128'h1,{5'd2,5'd2}}, '{0,0,5'd0,2'd0,32'h0,128'h0,2'b00,2'b00,2'b00}});
        vt.push_back('{'{0,0,1,1,0,5'd10,2'd2,32'h10,128'h2,{5'd10,5'd10}}, '{1,0,5'd0,2'd1,32'h10,128'h2,2'b00,2'b00,2'b00}});
        for (int i = 0; i < vt.size(); i++)
            apply(vt[i], $sformatf("v%0d", i));
        // query outputs must ignore *_i between edges; ports evaluate independently
        apply('{'{0,0,1,1,1,5'd7,2'd0,32'hcafe,128'h3,{5'd7,5'd7}}, '{1,1,5'd7,2'd0,32'hcafe,128'h3,2'b11,2'b11,2'b00}}, "q_load");
        en = 1'b0; valid_i = 1'b0; we_i = 1'b0; a3_i = 5'd0; tnew_i = 2'd3; wd_i = 32'h0;
        #2;
        chk("q_noinpath_rdy", src_rdy_o, 2'b11);
        chk("q_noinpath_tnew", tnew_o, 2'd0);
        chk("q_noinpath_fwd", fwd_data_o, 32'hcafe);
        src_addr_i = {5'd7, 5'd0};
        #1;
        chk("q_port_split_hit", src_hit_o, 2'b10);
        chk("q_port_split_rdy", src_rdy_o, 2'b10);
        if (sb.size() != 0) chk("sb_leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
